mode_counter: RTL and testbench
===============================

# mode_counter

Parametrised, synchronous up/down counter: the next generation of the team's free-running 8-bit counter. Adds a configurable modulus, enable, load, count direction, wrap/saturate mode, terminal-count pulse, sticky overflow flag and a compare output. Used as the general-purpose event/cycle counter in the computer-architecture lab datapaths.

## Interface
- WIDTH, 8, counter width in bits (1..32).
- MAX_VALUE, 2**WIDTH-1, top count; the counter runs 0..MAX_VALUE (modulus MAX_VALUE+1); must be ≤ 2**WIDTH-1.
- RESET_VALUE, 0, count after reset; must be ≤ MAX_VALUE.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable; count advances one step per cycle while high.
- up_dn  input  1  direction: 1 = up, 0 = down.
- sat_mode  input  1  1 = saturate at the limits, 0 = wrap at the limits.
- load  input  1  synchronous load of load_value.
- load_value  input  WIDTH  value to load.
- clear_ovf  input  1  clears the sticky ovf flag.
- cmp_value  input  WIDTH  compare reference.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered.
- ovf  output  1  sticky overflow/underflow flag, registered.
- cmp_match  output  1  combinational, count == cmp_value.

## Operation
- Priority per edge: reset > load > en > hold.
- reset: count = RESET_VALUE, tc = 0, ovf = 0.
- load: count = load_value if load_value ≤ MAX_VALUE, else count = MAX_VALUE (clamp). No tc, no ovf change. en is ignored that cycle.
- en, up, count < MAX_VALUE: count + 1.
- en, up, count == MAX_VALUE: limit event; wrap mode → 0; saturate mode → holds MAX_VALUE.
- en, down, count > 0: count − 1.
- en, down, count == 0: limit event; wrap mode → MAX_VALUE; saturate mode → holds 0.
- Limit event: tc = 1 on the following cycle only; ovf set to 1.
- tc = 0 in every cycle not immediately following a limit event. Back-to-back limit events (saturated, en held) give tc high every cycle.
- ovf is sticky until clear_ovf or reset. If clear_ovf and a limit event occur in the same cycle, the set wins and ovf = 1.
- Arithmetic is modulo-free: next-count is selected explicitly, so count never exceeds MAX_VALUE, including when MAX_VALUE < 2**WIDTH−1.
- up_dn and sat_mode may change on any cycle and take effect on that cycle's edge.
- en low: count, tc (→0) and ovf hold, except that clear_ovf still clears ovf.

## Timing
- Latency: count reflects a step, load or reset one edge after the control is sampled.
- tc and ovf update on the same edge as the count wrap or saturate.
- cmp_match follows count combinationally, with no extra latency.
- Mid-operation reset overrides load/en in the same cycle. Counting resumes on the first edge with reset low.

## Test plan
- Reset/up-count: WIDTH=8, default params; reset 1 cycle, en=1, up → count 0,1,2…; after 255 → 0, tc=1 for exactly one cycle, ovf=1.
- Modulus wrap down: MAX_VALUE=9, load 1, down, wrap mode → 1,0,9,8; tc pulses once, the cycle count shows 9.
- Saturate: MAX_VALUE=9, load 8, up, sat_mode=1, en held 4 cycles → 9,9,9,9; tc=1 on each of the last three cycles; ovf=1.
- Load clamp/priority: MAX_VALUE=9, load=1 with load_value=200 and en=1 → count=9, tc=0. Then reset with load=1 → count=RESET_VALUE.
- ovf set/clear collision: ovf=1, assert clear_ovf → 0. Then clear_ovf coincident with a wrap 255→0 → ovf stays 1.
- Compare: cmp_value=5, count up from 0 → cmp_match high only while count=5; change cmp_value to 7 while count=7 → cmp_match rises in the same cycle.

Source files
------------

// File: rtl/mode_counter_if.sv
// mode_counter_if: control/status bundle for mode_counter.
//   master: drives the count controls (en, up_dn, sat_mode, load, load_value,
//           clear_ovf, cmp_value) and observes count, tc, ovf, cmp_match.
//   slave:  the counter itself.
interface mode_counter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic             up_dn;
  logic             sat_mode;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             clear_ovf;
  logic [WIDTH-1:0] cmp_value;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             ovf;
  logic             cmp_match;

  modport master (
    output en, up_dn, sat_mode, load, load_value, clear_ovf, cmp_value,
    input  count, tc, ovf, cmp_match
  );

  modport slave (
    input  en, up_dn, sat_mode, load, load_value, clear_ovf, cmp_value,
    output count, tc, ovf, cmp_match
  );
endinterface

// File: rtl/mode_counter.sv
// mode_counter: parametrised synchronous up/down counter with modulus MAX_VALUE+1,
// load with clamp, wrap or saturate at the limits, one-cycle terminal-count pulse,
// sticky overflow flag and a combinational compare output.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    mode_counter_if.slave: en, up_dn, sat_mode, load, load_value, clear_ovf,
//          cmp_value in; count, tc, ovf (registered) and cmp_match (combinational) out
module mode_counter #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] MAX_VALUE   = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic           clk,
  input logic           reset,
  mode_counter_if.slave bus
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             at_limit;

  // Limit depends on direction: top of range going up, zero going down.
  assign at_limit = bus.up_dn ? (count_q == MAX_VALUE) : (count_q == '0);

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q & ~bus.clear_ovf;
    if (bus.load) begin
      // Out-of-range loads clamp so count never leaves 0..MAX_VALUE.
      count_d = (bus.load_value > MAX_VALUE) ? MAX_VALUE : bus.load_value;
    end else if (bus.en) begin
      if (at_limit) begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;  // a limit event beats a coincident clear
        if (!bus.sat_mode) begin
          count_d = bus.up_dn ? '0 : MAX_VALUE;
        end
      end else begin
        count_d = bus.up_dn ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= RESET_VALUE;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.count     = count_q;
  assign bus.tc        = tc_q;
  assign bus.ovf       = ovf_q;
  assign bus.cmp_match = (count_q == bus.cmp_value);

endmodule

// File: tb/tb_mode_counter.sv
module tb_mode_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, up_dn, sat_mode, load, clear_ovf;
  logic [7:0] load_value, cmp_value;

  always #5 clk = ~clk;

  mode_counter_if #(.WIDTH(8)) if8 ();
  mode_counter_if #(.WIDTH(8)) if9 ();

  assign if8.en = en;            assign if9.en = en;
  assign if8.up_dn = up_dn;      assign if9.up_dn = up_dn;
  assign if8.sat_mode = sat_mode; assign if9.sat_mode = sat_mode;
  assign if8.load = load;        assign if9.load = load;
  assign if8.load_value = load_value; assign if9.load_value = load_value;
  assign if8.clear_ovf = clear_ovf;   assign if9.clear_ovf = clear_ovf;
  assign if8.cmp_value = cmp_value;   assign if9.cmp_value = cmp_value;

  mode_counter #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(if8));
  mode_counter #(.WIDTH(8), .MAX_VALUE(8'd9)) dut9 (.clk(clk), .reset(reset), .bus(if9));

  int nvec = 0;
  int nerr = 0;

  // Behavioural model: index 0 = default 0..255 counter, 1 = 0..9 counter.
  int m_cnt[2];
  bit m_tc[2];
  bit m_ovf[2];
  int maxv[2] = '{255, 9};

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      int mx = maxv[d];
      if (reset) begin
        m_cnt[d] = 0; m_tc[d] = 0; m_ovf[d] = 0;
      end else begin
        bit limit;
        m_tc[d] = 0;
        if (clear_ovf) m_ovf[d] = 0;
        if (load) begin
          m_cnt[d] = (int'(load_value) > mx) ? mx : int'(load_value);
        end else if (en) begin
          limit = up_dn ? (m_cnt[d] == mx) : (m_cnt[d] == 0);
          if (limit) begin
            m_tc[d] = 1; m_ovf[d] = 1;
            if (!sat_mode) m_cnt[d] = up_dn ? 0 : mx;
          end else begin
            m_cnt[d] = up_dn ? m_cnt[d] + 1 : m_cnt[d] - 1;
          end
        end
      end
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, " cnt8"}, int'(if8.count), m_cnt[0]);
    check({tag, " tc8"}, int'(if8.tc), int'(m_tc[0]));
    check({tag, " ovf8"}, int'(if8.ovf), int'(m_ovf[0]));
    check({tag, " cmp8"}, int'(if8.cmp_match), int'(m_cnt[0] == int'(cmp_value)));
    check({tag, " cnt9"}, int'(if9.count), m_cnt[1]);
    check({tag, " tc9"}, int'(if9.tc), int'(m_tc[1]));
    check({tag, " ovf9"}, int'(if9.ovf), int'(m_ovf[1]));
    check({tag, " cmp9"}, int'(if9.cmp_match), int'(m_cnt[1] == int'(cmp_value)));
  endtask

  // One clock edge: update the model from the pre-edge inputs, sample 1 unit later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input bit r, input bit e, input bit u, input bit s, input bit l,
                        input logic [7:0] lv, input bit c, input logic [7:0] cv);
    reset = r; en = e; up_dn = u; sat_mode = s; load = l;
    load_value = lv; clear_ovf = c; cmp_value = cv;
  endtask

  typedef struct {
    bit         rst, e, up, sat, ld;
    logic [7:0] lv;
    bit         clr;
    logic [7:0] cmp;
    int         cnt;
    bit         tc, ovf, match;
  } vec_t;

  vec_t vecs[18];

  initial begin
    // Expected state of the 0..9 counter after each edge.
    //          rst e up sat ld  lv    clr cmp    cnt tc ovf match
    vecs[0]  = '{1, 0, 1, 0, 0, 8'd0,   0, 8'd0,  0, 0, 0, 1};
    vecs[1]  = '{0, 0, 0, 0, 1, 8'd1,   0, 8'd5,  1, 0, 0, 0};
    vecs[2]  = '{0, 1, 0, 0, 0, 8'd0,   0, 8'd5,  0, 0, 0, 0};
    vecs[3]  = '{0, 1, 0, 0, 0, 8'd0,   0, 8'd9,  9, 1, 1, 1};
    vecs[4]  = '{0, 1, 0, 0, 0, 8'd0,   0, 8'd9,  8, 0, 1, 0};
    vecs[5]  = '{0, 0, 1, 1, 1, 8'd8,   0, 8'd9,  8, 0, 1, 0};
    vecs[6]  = '{0, 1, 1, 1, 0, 8'd0,   0, 8'd9,  9, 0, 1, 1};
    vecs[7]  = '{0, 1, 1, 1, 0, 8'd0,   0, 8'd9,  9, 1, 1, 1};
    vecs[8]  = '{0, 1, 1, 1, 0, 8'd0,   0, 8'd9,  9, 1, 1, 1};
    vecs[9]  = '{0, 1, 1, 1, 0, 8'd0,   0, 8'd9,  9, 1, 1, 1};
    vecs[10] = '{0, 0, 1, 1, 0, 8'd0,   1, 8'd9,  9, 0, 0, 1};
    vecs[11] = '{0, 1, 1, 0, 1, 8'd200, 0, 8'd9,  9, 0, 0, 1};
    vecs[12] = '{1, 1, 1, 0, 1, 8'd3,   0, 8'd9,  0, 0, 0, 0};
    vecs[13] = '{0, 1, 1, 0, 0, 8'd0,   0, 8'd9,  1, 0, 0, 0};
    vecs[14] = '{0, 0, 1, 0, 1, 8'd9,   0, 8'd9,  9, 0, 0, 1};
    vecs[15] = '{0, 1, 1, 0, 0, 8'd0,   1, 8'd0,  0, 1, 1, 1};
    vecs[16] = '{0, 0, 1, 0, 0, 8'd0,   0, 8'd0,  0, 0, 1, 1};
    vecs[17] = '{0, 1, 1, 0, 0, 8'd0,   0, 8'd1,  1, 0, 1, 1};

    set_in(1, 0, 1, 0, 0, 8'd0, 0, 8'd0);
    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      set_in(vecs[i].rst, vecs[i].e, vecs[i].up, vecs[i].sat, vecs[i].ld, vecs[i].lv,
             vecs[i].clr, vecs[i].cmp);
      tick();
      check($sformatf("vec%0d cnt", i), int'(if9.count), vecs[i].cnt);
      check($sformatf("vec%0d tc", i), int'(if9.tc), int'(vecs[i].tc));
      check($sformatf("vec%0d ovf", i), int'(if9.ovf), int'(vecs[i].ovf));
      check($sformatf("vec%0d match", i), int'(if9.cmp_match), int'(vecs[i].match));
      compare_model($sformatf("vec%0d model", i));
    end

    // Full up-count of the default counter with cmp_value=5, through the 255->0 wrap.
    set_in(1, 0, 1, 0, 0, 8'd0, 0, 8'd5);
    tick();
    check("rst cnt8", int'(if8.count), 0);
    check("rst ovf8", int'(if8.ovf), 0);
    en = 1;
    for (int i = 1; i <= 255; i++) begin
      reset = 0;
      tick();
      if (int'(if8.count) != i || if8.tc || if8.ovf || (if8.cmp_match != (i == 5)))
        check($sformatf("upcount %0d", i),
              {int'(if8.count), int'(if8.tc), int'(if8.ovf), int'(if8.cmp_match)},
              {i, 0, 0, int'(i == 5)});
      else nvec++;
    end
    tick();
    check("wrap cnt8", int'(if8.count), 0);
    check("wrap tc8", int'(if8.tc), 1);
    check("wrap ovf8", int'(if8.ovf), 1);
    tick();
    check("post-wrap cnt8", int'(if8.count), 1);
    check("post-wrap tc8", int'(if8.tc), 0);
    compare_model("wrap model");

    // Clear alone, then clear colliding with a 255->0 wrap.
    en = 0; clear_ovf = 1;
    tick();
    check("clear ovf8", int'(if8.ovf), 0);
    clear_ovf = 0; load = 1; load_value = 8'd255;
    tick();
    load = 0; en = 1; clear_ovf = 1;
    tick();
    check("collide cnt8", int'(if8.count), 0);
    check("collide ovf8", int'(if8.ovf), 1);
    compare_model("collide model");

    // cmp_value change follows with no clock edge.
    set_in(0, 0, 1, 0, 1, 8'd7, 0, 8'd5);
    tick();
    load = 0;
    check("cmp 5 vs 7", int'(if8.cmp_match), 0);
    cmp_value = 8'd7;
    #1;
    check("cmp 7 vs 7 (8)", int'(if8.cmp_match), 1);
    check("cmp 7 vs 7 (9)", int'(if9.cmp_match), 1);

    // Randomised phase with direction bias blocks so both limits are reached.
    for (int blk = 0; blk < 40; blk++) begin
      int bias = $urandom_range(0, 8);
      for (int c = 0; c < 64; c++) begin
        reset     = ($urandom % 64) == 0;
        load      = ($urandom % 10) == 0;
        en        = ($urandom % 4) != 0;
        up_dn     = int'($urandom % 8) < bias;
        sat_mode  = ($urandom % 3) == 0;
        clear_ovf = ($urandom % 8) == 0;
        load_value = ($urandom % 2) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(240, 255));
        cmp_value  = ($urandom % 2) ? 8'($urandom_range(0, 10)) : 8'($urandom);
        tick();
        compare_model($sformatf("rand b%0d c%0d", blk, c));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
